// File: rtl/dm_access_arbiter.sv
// Arbitrates the single data-memory port between the EX-stage load/store port (cpu)
// and a loader/DMA port (dma); CPU has fixed priority bounded by a starvation counter.
module dm_access_arbiter #(
    parameter int AW           = 16,
    parameter int DW           = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_rw,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_stall,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dma_req,
    input  logic          dma_rw,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [DW-1:0] dma_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_en,
    output logic          mem_rw,
    output logic          mem_mux_sel,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]    starve_cnt;
    logic          at_limit;
    logic          win_dma;
    logic          win_cpu;
    logic          win_any;
    logic          win_rw;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;

    // Read-response tags: stage 1 = command on the bus, stage 2 = mem_rdata valid.
    logic s1_valid, s1_tag;
    logic s2_valid, s2_tag;

    // Gating with reset keeps both ports from being granted while held in reset.
    assign at_limit  = (starve_cnt == LIMIT);
    assign win_dma   = reset & dma_req & (~cpu_req | at_limit);
    assign win_cpu   = reset & cpu_req & ~win_dma;
    assign cpu_stall = cpu_req & ~win_cpu;
    assign dma_gnt   = win_dma;

    assign win_any   = win_cpu | win_dma;
    assign win_rw    = win_dma ? dma_rw    : cpu_rw;
    assign win_addr  = win_dma ? dma_addr  : cpu_addr;
    assign win_wdata = win_dma ? dma_wdata : cpu_wdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (win_dma || !dma_req) begin
            starve_cnt <= '0;
        end else if (win_cpu && !at_limit) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_en      <= 1'b0;
            mem_rw      <= 1'b0;
            mem_mux_sel <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
        end else if (win_any) begin
            mem_en      <= 1'b1;
            mem_rw      <= win_rw;
            mem_mux_sel <= ~win_rw;
            mem_addr    <= win_addr;
            mem_wdata   <= win_wdata;
        end else begin
            mem_en      <= 1'b0;
            mem_rw      <= 1'b0;
            mem_mux_sel <= 1'b0;
        end
    end

    // Tag 1 marks a DMA-owned read; the tags shift in lockstep so responses keep issue order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid   <= 1'b0;
            s1_tag     <= 1'b0;
            s2_valid   <= 1'b0;
            s2_tag     <= 1'b0;
            cpu_rvalid <= 1'b0;
            dma_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            dma_rdata  <= '0;
        end else begin
            s1_valid   <= win_any & ~win_rw;
            s1_tag     <= win_dma;
            s2_valid   <= s1_valid;
            s2_tag     <= s1_tag;
            cpu_rvalid <= s2_valid & ~s2_tag;
            dma_rvalid <= s2_valid & s2_tag;
            if (s2_valid && !s2_tag) begin
                cpu_rdata <= mem_rdata;
            end
            if (s2_valid && s2_tag) begin
                dma_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dm_access_arbiter.sv
// Directed bench for dm_access_arbiter: a small data-memory model, a stepping driver
// and an ordered scoreboard of expected read responses.
module tb_dm_access_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cpu_req = 1'b0, cpu_rw = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_stall, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          dma_req = 1'b0, dma_rw = 1'b0;
  logic [AW-1:0] dma_addr = '0;
  logic [DW-1:0] dma_wdata = '0;
  logic          dma_gnt, dma_rvalid;
  logic [DW-1:0] dma_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_en, mem_rw, mem_mux_sel;
  logic [DW-1:0] mem_rdata = '0;

  dm_access_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_rw(dma_rw), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_en(mem_en), .mem_rw(mem_rw),
    .mem_mux_sel(mem_mux_sel), .mem_rdata(mem_rdata)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // data memory: writes commit and reads launch at the edge closing the command cycle
  logic [DW-1:0] mem [0:255];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_rw) mem[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[7:0]];
    end
  end

  int total = 0;
  int bad = 0;
  // entry: {owner(1=dma), data[15:0], due cycle[15:0]}
  logic [32:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: every rvalid pulse must match the head of the expected queue
  always @(negedge clk) begin
    if (cpu_rvalid || dma_rvalid) begin
      logic [32:0] ent;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rvalid: got cpu=%b dma=%b want none (cycle %0d)",
                 cpu_rvalid, dma_rvalid, cyc);
      end else begin
        ent = exp_q.pop_front();
        check("rvalid_both", {31'd0, cpu_rvalid & dma_rvalid}, 32'd0);
        check("rsp_owner", {31'd0, dma_rvalid}, {31'd0, ent[32]});
        check("rsp_data", {16'd0, dma_rvalid ? dma_rdata : cpu_rdata}, {16'd0, ent[31:16]});
        check("rsp_cycle", {16'd0, 16'(cyc)}, {16'd0, ent[15:0]});
      end
    end
  end

  // driver: drive one cycle at the negedge, check arbitration, then the issued command
  task automatic step(input logic cr, input logic crw, input logic [15:0] ca, input logic [15:0] cw,
                      input logic dr, input logic drw, input logic [15:0] da, input logic [15:0] dw,
                      input logic e_stall, input logic e_gnt, input logic e_en, input logic e_rw,
                      input logic [15:0] e_addr, input logic [15:0] e_rdata, input logic push);
    @(negedge clk);
    cpu_req = cr; cpu_rw = crw; cpu_addr = ca; cpu_wdata = cw;
    dma_req = dr; dma_rw = drw; dma_addr = da; dma_wdata = dw;
    #1;
    check("cpu_stall", {31'd0, cpu_stall}, {31'd0, e_stall});
    check("dma_gnt", {31'd0, dma_gnt}, {31'd0, e_gnt});
    @(posedge clk);
    #1;
    check("mem_en", {31'd0, mem_en}, {31'd0, e_en});
    check("mem_rw", {31'd0, mem_rw}, {31'd0, e_rw});
    check("mem_mux_sel", {31'd0, mem_mux_sel}, {31'd0, e_en & ~e_rw});
    check("mem_addr", {16'd0, mem_addr}, {16'd0, e_addr});
    if (e_en && e_rw) check("mem_wdata", {16'd0, mem_wdata}, {16'd0, e_gnt ? dw : cw});
    if (push) exp_q.push_back({e_gnt, e_rdata, 16'(cyc + 2)});
  endtask

  task automatic idle(input int n, input logic [15:0] hold_addr);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, hold_addr, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[1] = 16'h1111; mem[2] = 16'h2222; mem[3] = 16'h3333; mem[16] = 16'hA5A5;

    // reset held with a pending CPU write
    cpu_req = 1; cpu_rw = 1; cpu_addr = 16'h0020; cpu_wdata = 16'h1234;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_en", {31'd0, mem_en}, 0);
    check("rst_mem_rw", {31'd0, mem_rw}, 0);
    check("rst_mux", {31'd0, mem_mux_sel}, 0);
    check("rst_addr", {16'd0, mem_addr}, 0);
    check("rst_wdata", {16'd0, mem_wdata}, 0);
    check("rst_rvalid", {30'd0, cpu_rvalid, dma_rvalid}, 0);
    check("rst_rdata", {cpu_rdata, dma_rdata}, 0);
    check("rst_stall", {31'd0, cpu_stall}, 1);
    check("rst_gnt", {31'd0, dma_gnt}, 0);
    reset = 1;
    step(1, 1, 16'h0020, 16'h1234, 0, 0, 0, 0, 0, 0, 1, 1, 16'h0020, 0, 0);

    // DMA-only read
    step(0, 0, 0, 0, 1, 0, 16'h0010, 0, 0, 1, 1, 0, 16'h0010, 16'hA5A5, 1);
    idle(3, 16'h0010);

    // mixed pipelined reads, returned in issue order
    step(1, 0, 16'h0001, 0, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0001, 16'h1111, 1);
    step(0, 0, 0, 0, 1, 0, 16'h0002, 0, 0, 1, 1, 0, 16'h0002, 16'h2222, 1);
    step(1, 0, 16'h0003, 0, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0003, 16'h3333, 1);
    idle(3, 16'h0003);

    // CPU write then read of the same address
    step(1, 1, 16'h0003, 16'hFFFF, 0, 0, 0, 0, 0, 0, 1, 1, 16'h0003, 0, 0);
    step(1, 0, 16'h0003, 0, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0003, 16'hFFFF, 1);
    idle(3, 16'h0003);

    // read then write of the same address: read sees the old value
    step(1, 0, 16'h0002, 0, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0002, 16'h2222, 1);
    step(1, 1, 16'h0002, 16'hBEEF, 0, 0, 0, 0, 0, 0, 1, 1, 16'h0002, 0, 0);
    step(0, 0, 0, 0, 1, 0, 16'h0002, 0, 0, 1, 1, 0, 16'h0002, 16'hBEEF, 1);
    idle(3, 16'h0002);

    // contention: C,C,C,C,D repeating
    for (int i = 0; i < 12; i++) begin
      logic d;
      d = (i % 5 == 4);
      step(1, 1, 16'h0040, 16'hC0C0, 1, 1, 16'h0041, 16'hD0D0,
           d, d, 1, 1, d ? 16'h0041 : 16'h0040, 0, 0);
    end
    idle(2, 16'h0040);

    // reset one cycle after a CPU read is accepted: the read is dropped
    step(1, 0, 16'h0001, 0, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0001, 0, 0);
    @(negedge clk);
    cpu_req = 0;
    reset = 0;
    #1;
    check("midrst_rdata", {16'd0, cpu_rdata}, 0);
    check("midrst_en", {31'd0, mem_en}, 0);
    repeat (2) @(negedge clk);
    reset = 1;
    idle(4, 16'h0000);
    check("post_rst_rdata", {16'd0, cpu_rdata}, 0);

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dm_access_arbiter.md
Name: dm_access_arbiter

Overview:
Shares the single data-memory block between two requesters: the pipeline EX-stage load/store port (cpu) and a secondary loader/DMA port (dma). It drives the memory command inputs: address (to ans_ex), store data (to DM_data), mem_en_ex, mem_rw_ex and mem_mux_sel_dm. It returns memory read data (from ans_dm) to whichever port issued the read. CPU has fixed priority, and a starvation counter guarantees DMA progress. It stalls the pipeline whenever the CPU loses arbitration.

Parameters:
AW, 16, address width
DW, 16, data width
STARVE_LIMIT, 4, consecutive CPU wins while dma_req pending before DMA is forced a slot (1..15)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
cpu_req  in  1  CPU access request
cpu_rw  in  1  1=write, 0=read
cpu_addr  in  AW  CPU address
cpu_wdata  in  DW  CPU store data
cpu_stall  out  1  CPU request not accepted this cycle; hold pipeline
cpu_rvalid  out  1  one-cycle pulse, cpu_rdata valid
cpu_rdata  out  DW  CPU read data
dma_req  in  1  DMA access request
dma_rw  in  1  1=write, 0=read
dma_addr  in  AW  DMA address
dma_wdata  in  DW  DMA store data
dma_gnt  out  1  DMA request accepted at next edge
dma_rvalid  out  1  one-cycle pulse, dma_rdata valid
dma_rdata  out  DW  DMA read data
mem_addr  out  AW  to data memory address (ans_ex)
mem_wdata  out  DW  to data memory store data (DM_data)
mem_en  out  1  to mem_en_ex
mem_rw  out  1  to mem_rw_ex, 1=write
mem_mux_sel  out  1  to mem_mux_sel_dm, 1=select memory read data
mem_rdata  in  DW  from ans_dm; valid in the cycle after a read command cycle

Behaviour:
- Reset (reset=0, async): mem_en=0, mem_rw=0, mem_mux_sel=0, mem_addr=0, mem_wdata=0, cpu_rvalid=0, dma_rvalid=0, cpu_rdata=0, dma_rdata=0, starve counter=0, in-flight read tags cleared.
  - Reads in flight at reset are dropped; no rvalid is produced for them after release.
  - While reset=0: dma_gnt=0 and cpu_stall=cpu_req.
- Arbitration (combinational, sampled at each rising edge):
  - win_dma = dma_req & (~cpu_req | starve_cnt==STARVE_LIMIT)
  - win_cpu = cpu_req & ~win_dma
  - cpu_stall = cpu_req & ~win_cpu
  - dma_gnt = win_dma
- Requester rule: a requester holds req/rw/addr/wdata stable until accepted. Dropping req before acceptance is legal and cancels the request.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) at each edge where win_cpu & dma_req.
  - Clears at an edge where win_dma or ~dma_req.
- Command stage (registered):
  - On an edge with a winner: mem_addr/mem_wdata/mem_rw load from the winner; mem_en=1; mem_mux_sel=~winner_rw.
  - On an edge with no winner: mem_en=0, mem_rw=0, mem_mux_sel=0; mem_addr and mem_wdata hold their previous values.
  - A read also loads a 1-bit owner tag plus a valid bit into stage 1.
- Response pipeline:
  - Stage-1 tag advances to stage 2 at the next edge.
  - At that edge mem_rdata is captured into the owner's rdata register, and the owner's rvalid pulses for exactly one cycle.
  - Non-owner rdata holds its value.
- Read latency: accepted at edge E0 -> command on bus E0..E1 -> mem_rdata valid E1..E2 -> rvalid/rdata E2..E3 (2 edges after acceptance).
- Writes: committed by memory during the command cycle; no response to the requester.
- Throughput: one access per cycle, fully pipelined. Back-to-back reads from mixed owners return in issue order.
- Simultaneous events: cpu_req & dma_req with starve_cnt<STARVE_LIMIT -> CPU wins. At the limit -> DMA wins, and the CPU stalls exactly one cycle.
- Read followed by a write to the same address on the next edge: the read returns the pre-write data. No forwarding.

Test Plan:
- Reset: hold reset=0 with cpu_req=1 -> all mem_*/rvalid outputs 0, cpu_stall=1, dma_gnt=0; release, first edge issues the CPU access.
- CPU write then read: cpu write addr 0x0003 data 0xFFFF, next cycle read 0x0003 -> mem_en=1/mem_rw=1/mem_mux_sel=0, then mem_rw=0/mem_mux_sel=1; cpu_rvalid pulses 2 edges after the read is accepted with cpu_rdata=0xFFFF; cpu_stall stays 0.
- DMA only: dma read 0x0010 (memory preloaded 0xA5A5) -> dma_gnt=1 for one cycle, dma_rvalid pulse with 0xA5A5; cpu_rvalid stays 0.
- Contention/starvation: cpu_req and dma_req both held high for 12 cycles, STARVE_LIMIT=4 -> grant pattern C,C,C,C,D repeating; cpu_stall high on each D cycle; counter clears after each D.
- Mixed pipelined reads: edges CPU rd 0x0001 (0x1111), DMA rd 0x0002 (0x2222), CPU rd 0x0003 (0x3333) -> rvalids on consecutive cycles in issue order, each to the correct port with the correct data.
- Reset mid-read: assert reset=0 one cycle after a CPU read is accepted -> no cpu_rvalid after release; cpu_rdata=0.
